// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the Z80 I/O write decode and the UART
// transmitter. Circular memory with a separate level counter, a registered
// output stage driven by a small FSM, and a sticky overflow flag.
//
// Handshake: tx_data is offered while tx_data_valid is high and is held
// stable until a cycle where tx_data_valid && tx_data_ready are both high;
// that cycle is the one and only transfer of the byte.
//
// Optional build macro UART_TX_FIFO_CRLF_EN: a bare LF (0x0A not preceded
// by a transferred CR) is sent as CR followed by LF.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_data_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1
`ifdef UART_TX_FIFO_CRLF_EN
        , S_CR = 2'd2
`endif
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_q;
    logic [7:0]            tx_data_q;
    logic                  overflow_q;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic [7:0]            load_val;
    logic                  take_head;
    logic                  xfer;
    logic [7:0]            head;
`ifdef UART_TX_FIFO_CRLF_EN
    logic                  last_cr;
    logic                  cr_seen;
`endif

    // full is judged on the registered level, so a write while full is
    // dropped even if a pop happens in the same cycle
    assign full          = (level_q == LEVEL_FULL);
    assign push          = wr_en && !full;
    assign tx_data_valid = (state != S_IDLE);
    assign xfer          = tx_data_valid && tx_data_ready;
    assign head          = mem[rd_ptr];
    assign empty         = (level_q == '0) && !tx_data_valid;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign tx_data       = tx_data_q;

`ifdef UART_TX_FIFO_CRLF_EN
    // The byte leaving in this cycle's transfer counts as "previous" for the
    // head decision; in S_IDLE the registered flag already holds it.
    assign cr_seen = (state == S_HOLD) ? (tx_data_q == 8'h0D) : last_cr;
`endif

    // Output FSM: decide whether to load the output register and pop the head
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_val  = head;
        take_head = 1'b0;
        case (state)
            S_IDLE: take_head = (level_q != '0);
            S_HOLD: begin
                if (xfer) begin
                    if (level_q != '0) take_head = 1'b1;
                    else               state_nxt = S_IDLE;
                end
            end
`ifdef UART_TX_FIFO_CRLF_EN
            S_CR: begin
                // inserted CR accepted; the LF still at the head goes next
                if (xfer) begin
                    load      = 1'b1;
                    pop       = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
        if (take_head) begin
`ifdef UART_TX_FIFO_CRLF_EN
            if (head == 8'h0A && !cr_seen) begin
                load      = 1'b1;
                load_val  = 8'h0D;
                state_nxt = S_CR;
            end else begin
                load      = 1'b1;
                pop       = 1'b1;
                state_nxt = S_HOLD;
            end
`else
            load      = 1'b1;
            pop       = 1'b1;
            state_nxt = S_HOLD;
`endif
        end
    end

    // Storage array; contents are not reset, level gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers, level, output register, overflow and FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (load) tx_data_q <= load_val;
            // a dropped write wins over a clear in the same cycle
            if (wr_en && full) overflow_q <= 1'b1;
            else if (ovf_clr)  overflow_q <= 1'b0;
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    // Remember whether the most recently transferred byte was a CR
    always_ff @(posedge clk) begin
        if (rst)       last_cr <= 1'b0;
        else if (xfer) last_cr <= (tx_data_q == 8'h0D);
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios plus random traffic,
// checked against a queue-based reference model and a byte scoreboard.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef UART_TX_FIFO_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                ovf_clr;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;
    logic [7:0]          tx_data;
    logic                tx_data_valid;
    logic                tx_data_ready;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .ovf_clr       (ovf_clr),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];       // bytes held in memory, oldest first
    logic       m_valid;      // a byte is being offered
    logic [7:0] m_out;        // byte on tx_data
    logic       m_cr_pend;    // offered byte is an inserted CR, LF still queued
    logic       m_lastcr;     // last transferred byte was CR
    logic       m_ovf;
    logic [7:0] exp_q[$];     // scoreboard: bytes expected on the transfer side
    logic [7:0] prev_acc;     // last accepted byte (for LF expansion)
    logic [7:0] xfer_log[$];  // bytes actually transferred, for directed checks

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_valid   = 1'b0;
        m_out     = 8'h00;
        m_cr_pend = 1'b0;
        m_lastcr  = 1'b0;
        m_ovf     = 1'b0;
        prev_acc  = 8'h00;
    endtask

    task automatic model_clock();
        logic xfer, accept, lastcr_new;
        if (rst) begin
            model_reset();
            return;
        end
        xfer       = m_valid && tx_data_ready;
        accept     = wr_en && (m_q.size() < DEPTH);
        lastcr_new = xfer ? (m_out == 8'h0D) : m_lastcr;
        if (m_cr_pend) begin
            if (xfer) begin
                m_out     = m_q.pop_front();
                m_cr_pend = 1'b0;
            end
        end else if (!m_valid || xfer) begin
            if (m_q.size() > 0) begin
                if (CRLF && m_q[0] == 8'h0A && !lastcr_new) begin
                    m_out     = 8'h0D;
                    m_cr_pend = 1'b1;
                end else begin
                    m_out = m_q.pop_front();
                end
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_lastcr = lastcr_new;
        if (wr_en && !accept) m_ovf = 1'b1;
        else if (ovf_clr)     m_ovf = 1'b0;
        if (accept) begin
            if (CRLF && wr_data == 8'h0A && prev_acc != 8'h0D) exp_q.push_back(8'h0D);
            exp_q.push_back(wr_data);
            prev_acc = wr_data;
            m_q.push_back(wr_data);
        end
    endtask

    task automatic compare_all();
        check("level",    32'(level),         32'(m_q.size()));
        check("full",     32'(full),          32'(m_q.size() == DEPTH));
        check("empty",    32'(empty),         32'(m_q.size() == 0 && !m_valid));
        check("valid",    32'(tx_data_valid), 32'(m_valid));
        check("overflow", 32'(overflow),      32'(m_ovf));
        check("tx_data",  32'(tx_data),       32'(m_out));
    endtask

    // ---------------- driver ----------------
    // One clock: score a transfer seen before the edge, advance the model on
    // the edge, compare on the falling edge. Inputs change after the compare.
    task automatic step();
        if (!rst && m_valid && tx_data_ready) begin
            xfer_log.push_back(tx_data);
            if (exp_q.size() == 0) check("sb_extra", 32'(tx_data), 32'h100);
            else                   check("sb_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int i;
        wr_en = 1'b0; ovf_clr = 1'b0; tx_data_ready = 1'b1;
        for (i = 0; i < 200 && (tx_data_valid || level != 0); i++) step();
        check("drain_bound", 32'(i < 200), 32'd1);
        check("drain_empty", 32'(empty), 32'd1);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        tx_data_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] exp_crlf[$];
        int wr_pct, rd_pct, r;

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; tx_data_ready = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 32'(tx_data_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_full",  32'(full), 32'd0);
        check("rst_data",  32'(tx_data), 32'd0);

        // single byte: write at N, level at N+1, valid at N+2
        write_byte(8'h41);
        check("single_lvl1", 32'(level), 32'd1);
        check("single_nv",   32'(tx_data_valid), 32'd0);
        step();
        check("single_valid", 32'(tx_data_valid), 32'd1);
        check("single_data",  32'(tx_data), 32'h41);
        tx_data_ready = 1'b1;
        step();
        tx_data_ready = 1'b0;
        check("single_done",  32'(tx_data_valid), 32'd0);
        check("single_empty", 32'(empty), 32'd1);

        // fill: 17 bytes, one in the output register and 16 in memory
        for (int i = 0; i <= 16; i++) write_byte(8'(i));
        step();
        check("fill_level", 32'(level), 32'd16);
        check("fill_full",  32'(full), 32'd1);
        check("fill_ovf",   32'(overflow), 32'd0);
        check("fill_head",  32'(tx_data), 32'h00);
        write_byte(8'h11);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd16);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        // write while full with a pop in the same cycle is still dropped
        tx_data_ready = 1'b1;
        write_byte(8'hEE);
        tx_data_ready = 1'b0;
        check("ovf_pop_set",   32'(overflow), 32'd1);
        check("ovf_pop_level", 32'(level), 32'd15);
        write_byte(8'h22);
        // drop and clear together: set wins
        ovf_clr = 1'b1; write_byte(8'h33); ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        drain();

        // LF expansion sequence
        xfer_log.delete();
        tx_data_ready = 1'b1;
        write_byte(8'h61); write_byte(8'h0A); write_byte(8'h0D); write_byte(8'h0A);
        drain();
        if (CRLF) exp_crlf = '{8'h61, 8'h0D, 8'h0A, 8'h0D, 8'h0A};
        else      exp_crlf = '{8'h61, 8'h0A, 8'h0D, 8'h0A};
        check("crlf_len", 32'(xfer_log.size()), 32'(exp_crlf.size()));
        for (int i = 0; i < exp_crlf.size() && i < xfer_log.size(); i++)
            check("crlf_byte", 32'(xfer_log[i]), 32'(exp_crlf[i]));

        // reset mid-stream
        for (int i = 0; i < 6; i++) write_byte(8'hA0 + 8'(i));
        step();
        check("mid_level", 32'(level), 32'd5);
        check("mid_valid", 32'(tx_data_valid), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_rst_valid", 32'(tx_data_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        xfer_log.delete();
        write_byte(8'h55);
        drain();
        check("mid_new_len",  32'(xfer_log.size()), 32'd1);
        if (xfer_log.size() > 0) check("mid_new_byte", 32'(xfer_log[0]), 32'h55);

        // random traffic with changing write/read pressure
        wr_pct = 50; rd_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                wr_pct = $urandom_range(10, 95);
                rd_pct = $urandom_range(5, 100);
            end
            rst           = ($urandom_range(0, 999) == 0);
            wr_en         = ($urandom_range(0, 99) < wr_pct);
            tx_data_ready = ($urandom_range(0, 99) < rd_pct);
            ovf_clr       = ($urandom_range(0, 19) == 0);
            r             = $urandom_range(0, 9);
            wr_data       = (r < 2) ? 8'h0A : (r < 4) ? 8'h0D : 8'($urandom_range(0, 255));
            step();
        end
        rst = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
